// File: rtl/stepmotor_nios2_gen2_0_cpu_debug_action_sched.sv
// stepmotor_nios2_gen2_0_cpu_debug_action_sched
//   Collects take_action_* strobes from the debug-slave sysclk stage into
//   per-source pending slots, and hands them to the OCI back end one at a
//   time. Sources are granted round-robin. A command is held until the OCI
//   reports completion.
//
//   Handshake: a command transfers on the rising edge where cmd_valid and
//   cmd_ready are both high. Once cmd_valid is raised, cmd_src and cmd_data
//   stay stable and cmd_valid stays high until that transfer. After the
//   transfer the scheduler waits for rsp_done. It then spends one IDLE cycle
//   before it offers the next command.
//
//   Optional feature macro: DBG_SCHED_TIMEOUT_EN. When it is defined, a
//   command outstanding for TIMEOUT_CYC cycles without rsp_done is abandoned
//   and the sticky timeout_err flag is set. Without the macro, WAIT has no
//   limit and timeout_err is tied low.
//
//   dbg_state exposes the FSM state (0 IDLE, 1 ISSUE, 2 WAIT).

module stepmotor_nios2_gen2_0_cpu_debug_action_sched #(
  parameter int N_SRC       = 6,
  parameter int DATA_W      = 38,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  act_strobe,
  input  logic [DATA_W-1:0] jdo,
  output logic              cmd_valid,
  output logic [2:0]        cmd_src,
  output logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_ready,
  input  logic              rsp_done,
  input  logic              err_clr,
  output logic              busy,
  output logic [N_SRC-1:0]  pending,
  output logic [N_SRC-1:0]  overrun,
  output logic              timeout_err,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // A zero timeout would make the WAIT counter meaningless.
  if (TIMEOUT_CYC < 1) begin : g_timeout_guard
    $error("TIMEOUT_CYC must be at least 1");
  end

  logic [1:0]        state_q, state_d;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  overrun_q, overrun_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [2:0]        grant_q, grant_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
  logic [DATA_W-1:0] slot_q [N_SRC];

  logic              accept;
  logic [N_SRC-1:0]  acc_clr;
  logic [N_SRC-1:0]  pend_after_acc;
  logic [N_SRC-1:0]  slot_we;
  logic              pick_found;
  logic [2:0]        pick_idx;
  logic [3:0]        cand;
  logic              timeout_hit;

  assign accept = (state_q == ST_ISSUE) && cmd_ready;

  // The source that is accepted this cycle frees its slot first. A strobe
  // for that same source in the same cycle is then a fresh capture, not an
  // overrun.
  always_comb begin
    acc_clr        = accept ? (N_SRC'(1) << grant_q) : '0;
    pend_after_acc = pending_q & ~acc_clr;
    slot_we        = act_strobe & ~pend_after_acc;
    pending_d      = pend_after_acc | act_strobe;
    // A new overrun event beats a simultaneous err_clr.
    overrun_d      = (err_clr ? '0 : overrun_q) | (act_strobe & pend_after_acc);
  end

  // Round-robin search: find the first pending source at or after rr_ptr, wrapping at N_SRC.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = {1'b0, rr_ptr_q} + 4'(k);
      if (cand >= 4'(N_SRC)) cand = cand - 4'(N_SRC);
      if (!pick_found && pending_q[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand[2:0];
      end
    end
  end

  // FSM next-state logic: grant in IDLE, offer in ISSUE, wait for completion in WAIT.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cmd_data_d = cmd_data_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          cmd_data_d = slot_q[pick_idx];
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // rsp_done is ignored here. Only the handshake moves the FSM on.
        if (cmd_ready) begin
          rr_ptr_d = (grant_q == 3'(N_SRC - 1)) ? 3'd0 : grant_q + 3'd1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rsp_done || timeout_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef DBG_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            timeout_q, timeout_d;

  // The WAIT cycle counter is held at zero outside WAIT, so every WAIT entry starts from zero.
  always_comb begin
    timeout_hit = (state_q == ST_WAIT) && !rsp_done &&
                  (wait_cnt_q == TO_W'(TIMEOUT_CYC - 1));
    wait_cnt_d  = '0;
    if ((state_q == ST_WAIT) && !rsp_done && !timeout_hit)
      wait_cnt_d = wait_cnt_q + TO_W'(1);
    // A new timeout beats a simultaneous err_clr.
    timeout_d   = (err_clr ? 1'b0 : timeout_q) | timeout_hit;
  end

  // Registers for the timeout counter and the sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Registers for the FSM state, the grant, the round-robin pointer and the flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      overrun_q  <= '0;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      cmd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      cmd_data_q <= cmd_data_d;
    end
  end

  // Payload slots load only on a non-overrun capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_SRC; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (slot_we[i]) slot_q[i] <= jdo;
      end
    end
  end

  assign cmd_valid = (state_q == ST_ISSUE);
  assign busy      = (state_q != ST_IDLE);
  assign cmd_src   = grant_q;
  assign cmd_data  = cmd_data_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stepmotor_nios2_gen2_0_cpu_debug_action_sched.sv
// Bench for stepmotor_nios2_gen2_0_cpu_debug_action_sched. Directed scenarios
// are followed by randomized traffic. A cycle-level behavioural model built
// from sets, arrays and modulo arithmetic predicts the outputs.

`timescale 1ns/1ps

module tb_stepmotor_nios2_gen2_0_cpu_debug_action_sched;

  localparam int N_SRC  = 6;
  localparam int DATA_W = 38;
  localparam int TB_TO  = 8;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic [N_SRC-1:0]  act_strobe;
  logic [DATA_W-1:0] jdo;
  logic              cmd_valid;
  logic [2:0]        cmd_src;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_ready;
  logic              rsp_done;
  logic              err_clr;
  logic              busy;
  logic [N_SRC-1:0]  pending;
  logic [N_SRC-1:0]  overrun;
  logic              timeout_err;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  stepmotor_nios2_gen2_0_cpu_debug_action_sched #(
    .N_SRC(N_SRC), .DATA_W(DATA_W), .TIMEOUT_CYC(TB_TO)
  ) dut (
    .clk(clk), .reset(reset), .act_strobe(act_strobe), .jdo(jdo),
    .cmd_valid(cmd_valid), .cmd_src(cmd_src), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .rsp_done(rsp_done), .err_clr(err_clr),
    .busy(busy), .pending(pending), .overrun(overrun),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // m_phase: 0 = nothing offered, 1 = command offered, 2 = command outstanding
  int                m_phase, m_rr, m_cur, m_wait;
  bit [N_SRC-1:0]    m_pend, m_ovr;
  bit                m_to;
  logic [DATA_W-1:0] m_slot [N_SRC];
  logic [DATA_W-1:0] m_data;

  task automatic model_reset();
    m_phase = 0; m_rr = 0; m_cur = 0; m_wait = 0;
    m_pend = '0; m_ovr = '0; m_to = 1'b0; m_data = '0;
    for (int i = 0; i < N_SRC; i++) m_slot[i] = '0;
  endtask

  // Advance the model by one clock edge, using the inputs applied for that edge.
  task automatic model_step();
    if (err_clr) begin m_ovr = '0; m_to = 1'b0; end
    case (m_phase)
      0: if (m_pend != '0) begin
           for (int k = 0; k < N_SRC; k++) begin
             if (m_pend[(m_rr + k) % N_SRC]) begin m_cur = (m_rr + k) % N_SRC; break; end
           end
           m_data  = m_slot[m_cur];
           m_phase = 1;
         end
      1: if (cmd_ready) begin
           m_pend[m_cur] = 1'b0;
           m_rr    = (m_cur + 1) % N_SRC;
           m_phase = 2;
           m_wait  = 0;
         end
      default: begin
        if (rsp_done) m_phase = 0;
        else begin
`ifdef DBG_SCHED_TIMEOUT_EN
          m_wait++;
          if (m_wait == TB_TO) begin m_phase = 0; m_to = 1'b1; end
`endif
        end
      end
    endcase
    for (int i = 0; i < N_SRC; i++) begin
      if (act_strobe[i]) begin
        if (m_pend[i]) m_ovr[i] = 1'b1;
        else begin m_pend[i] = 1'b1; m_slot[i] = jdo; end
      end
    end
  endtask

  task automatic compare_all(input string ctx);
    chk({ctx, ".valid"},   64'(cmd_valid),   64'(m_phase == 1));
    chk({ctx, ".busy"},    64'(busy),        64'(m_phase != 0));
    chk({ctx, ".pending"}, 64'(pending),     64'(m_pend));
    chk({ctx, ".overrun"}, 64'(overrun),     64'(m_ovr));
    chk({ctx, ".tmo"},     64'(timeout_err), 64'(m_to));
    chk({ctx, ".src"},     64'(cmd_src),     64'(m_cur));
    chk({ctx, ".data"},    64'(cmd_data),    64'(m_data));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input string ctx);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(ctx);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    act_strobe = '0; cmd_ready = 1'b0; rsp_done = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rand_jdo();
    return {6'($urandom), 32'($urandom)};
  endfunction

  logic [DATA_W-1:0] pay_a, pay_b;
  logic [2:0]        exp_src;
  int                n_grants;

  initial begin
    reset = 1'b1; act_strobe = '0; jdo = '0;
    cmd_ready = 1'b0; rsp_done = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst.valid",   64'(cmd_valid),   64'd0);
    chk("rst.busy",    64'(busy),        64'd0);
    chk("rst.pending", 64'(pending),     64'd0);
    chk("rst.overrun", 64'(overrun),     64'd0);
    chk("rst.tmo",     64'(timeout_err), 64'd0);
    chk("rst.src",     64'(cmd_src),     64'd0);
    chk("rst.data",    64'(cmd_data),    64'd0);
    chk("rst.state",   64'(dbg_state),   64'd0);
    reset = 1'b0;

    // Single request: cmd_valid appears two edges after the strobe
    act_strobe = 6'b000001; jdo = 38'h1_2345_6789; cmd_ready = 1'b1;
    tick("single");
    act_strobe = '0; jdo = rand_jdo();
    chk("single.pend", 64'(pending), 64'h01);
    chk("single.novalid", 64'(cmd_valid), 64'd0);
    tick("single");
    chk("single.valid", 64'(cmd_valid), 64'd1);
    chk("single.src",   64'(cmd_src),   64'd0);
    chk("single.data",  64'(cmd_data),  64'h1_2345_6789);
    tick("single");
    chk("single.wait_busy", 64'(busy), 64'd1);
    rsp_done = 1'b1;
    tick("single");
    chk("single.idle", 64'(busy), 64'd0);
    rsp_done = 1'b0;

    // Simultaneous strobes: src 2 then src 5; the pointer then wraps to 0
    do_reset();
    act_strobe = 6'b100100; jdo = rand_jdo();
    tick("simul");
    act_strobe = '0; cmd_ready = 1'b1; rsp_done = 1'b1;
    exp_q = {3'd2, 3'd5}; n_grants = 0;
    for (int cyc = 0; cyc < 40 && (exp_q.size() > 0 || busy || pending != '0); cyc++) begin
      if (cmd_valid) begin
        n_grants++;
        if (exp_q.size() > 0) begin
          exp_src = exp_q.pop_front();
          chk("simul.order", 64'(cmd_src), 64'(exp_src));
        end
      end
      tick("simul");
    end
    chk("simul.grants",  64'(n_grants), 64'd2);
    chk("simul.drained", 64'(pending),  64'd0);

    // Round-robin: src 3 first; each granted source re-pends on acceptance, and src 0 joins.
    do_reset();
    cmd_ready = 1'b1; rsp_done = 1'b1;
    act_strobe = 6'b001000; jdo = rand_jdo();
    tick("rr");
    act_strobe = '0;
    exp_q = {3'd3, 3'd0, 3'd3, 3'd0, 3'd3, 3'd0}; n_grants = 0;
    for (int cyc = 0; cyc < 80 && exp_q.size() > 0; cyc++) begin
      act_strobe = '0; jdo = rand_jdo();
      if (cmd_valid) begin
        exp_src = exp_q.pop_front();
        chk("rr.order", 64'(cmd_src), 64'(exp_src));
        act_strobe = 6'(1 << cmd_src);
        if (n_grants == 0) act_strobe = act_strobe | 6'b000001;
        n_grants++;
      end
      tick("rr");
    end
    chk("rr.count", 64'(n_grants), 64'd6);
    act_strobe = '0;
    for (int cyc = 0; cyc < 40 && (busy || pending != '0); cyc++) tick("rr_drain");
    chk("rr.drained", 64'(pending), 64'd0);

    // Overrun, backpressure, err_clr, and reset in the middle of WAIT
    do_reset();
    pay_a = 38'h0_AAAA_0001; pay_b = 38'h3_5555_0002;
    act_strobe = 6'b000010; jdo = pay_a;
    tick("ovr");
    jdo = pay_b;
    tick("ovr");
    act_strobe = '0;
    chk("ovr.flag", 64'(overrun), 64'h02);
    for (int i = 0; i < 10; i++) begin
      tick("bp");
      chk("bp.valid", 64'(cmd_valid), 64'd1);
      chk("bp.data",  64'(cmd_data),  64'(pay_a));
    end
    err_clr = 1'b1;
    tick("ovr_clr");
    chk("ovr.cleared", 64'(overrun), 64'd0);
    act_strobe = 6'b000010; jdo = rand_jdo();
    tick("ovr_setwins");
    chk("ovr.setwins", 64'(overrun), 64'h02);
    act_strobe = '0;
    tick("ovr_clr2");
    err_clr = 1'b0; cmd_ready = 1'b1;
    tick("ovr_acc");
    cmd_ready = 1'b0;
    tick("ovr_wait");
    chk("ovr.in_wait", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst.valid",   64'(cmd_valid), 64'd0);
    chk("arst.busy",    64'(busy),      64'd0);
    chk("arst.pending", 64'(pending),   64'd0);
    chk("arst.overrun", 64'(overrun),   64'd0);
    chk("arst.data",    64'(cmd_data),  64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // WAIT with no rsp_done
    act_strobe = 6'b010000; jdo = rand_jdo(); cmd_ready = 1'b1;
    tick("tmo");
    act_strobe = '0;
    tick("tmo");
    tick("tmo");
    cmd_ready = 1'b0;
    repeat (TB_TO + 4) tick("tmo");
`ifdef DBG_SCHED_TIMEOUT_EN
    chk("tmo.flag", 64'(timeout_err), 64'd1);
    chk("tmo.idle", 64'(busy),        64'd0);
    rsp_done = 1'b1;
    tick("tmo_late");
    rsp_done = 1'b0; err_clr = 1'b1;
    tick("tmo_clr");
    err_clr = 1'b0;
    chk("tmo.cleared", 64'(timeout_err), 64'd0);
`else
    chk("tmo.busy", 64'(busy),        64'd1);
    chk("tmo.flag", 64'(timeout_err), 64'd0);
    rsp_done = 1'b1;
    tick("tmo_done");
    rsp_done = 1'b0;
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      act_strobe = ($urandom_range(0, 3) == 0) ? 6'($urandom) : '0;
      jdo        = rand_jdo();
      cmd_ready  = ($urandom_range(0, 3) != 0);
      rsp_done   = ($urandom_range(0, 2) == 0);
      err_clr    = ($urandom_range(0, 19) == 0);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
